// File: rtl/range_display_pkg.sv
// Shared types and constants for the range display back-end.
// Holds the conversion FSM encoding, datapath widths and the
// double-dabble iteration step used by range_bcd_display.
package range_display_pkg;

  typedef enum logic {IDLE, CONVERT} conv_state_t;

  localparam int NUM_DIGITS  = 4;
  localparam int BIN_W       = 12;
  localparam int BCD_W       = 16;
  localparam int CONV_CYCLES = 12;

  // A nibble at or above this value would exceed 9 after doubling.
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // One shift-add-3 iteration: correct every BCD nibble, then shift
  // the concatenated {bcd, bin} left by one bit.
  function automatic logic [BCD_W+BIN_W-1:0] dd_step(
    input logic [BCD_W-1:0] bcd,
    input logic [BIN_W-1:0] bin
  );
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[i*4 +: 4] >= ADD3_THRESH) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

endpackage

// File: rtl/range_bcd_display_seg7.sv
// Hex to 7-segment decoder shared across the range-finder codebase.
// Ports:
//   counter  [3:0] - nibble to display (0..F)
//   segments [6:0] - active-high pattern, bit order {g,f,e,d,c,b,a}
module seg7 (
  input  logic [3:0] counter,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h00;
    case (counter)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = 7'h00;
    endcase
  end

endmodule

// File: rtl/range_bcd_display.sv
// Four-digit decimal readout for the range-measurement chip.
// Converts a 12-bit binary result to BCD with an iterative
// double-dabble engine (12 cycles) and scans the digits onto one
// 7-segment bus.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   value_in    [11:0]  - binary value to display
//   value_valid         - load strobe, honoured only while idle
//   busy                - conversion in progress
//   segments    [6:0]   - pattern of the digit currently scanned
//   digit_en    [3:0]   - one-hot digit enable, bit 0 = ones
module range_bcd_display
  import range_display_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      value_in,
  input  logic                  value_valid,
  output logic                  busy,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] digit_en
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  conv_state_t      state;
  logic [BCD_W-1:0] bcd_sr;
  logic [BIN_W-1:0] bin_sr;
  logic [3:0]       bit_cnt;
  logic [BCD_W-1:0] disp_bcd;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       dig_idx;

  logic [BCD_W+BIN_W-1:0] step_res;
  logic                   conv_done;
  logic                   scan_wrap;
  logic [1:0]             dig_idx_nxt;
  logic [BCD_W-1:0]       disp_nxt;
  logic                   lit_nxt;
  logic [3:0]             cur_nib;

  assign step_res  = dd_step(bcd_sr, bin_sr);
  assign conv_done = (state == CONVERT) && (bit_cnt == 4'(CONV_CYCLES - 1));
  assign scan_wrap = (div_cnt == DIV_W'(SCAN_DIV - 1));

  // digit_en is registered, so it is computed from the values that
  // dig_idx and disp_bcd are about to take; this keeps the enable
  // aligned with the segments decoded from those same registers.
  always_comb begin
    dig_idx_nxt = scan_wrap ? dig_idx + 2'd1 : dig_idx;
    disp_nxt    = conv_done ? step_res[BCD_W+BIN_W-1 -: BCD_W] : disp_bcd;
    lit_nxt     = !BLANK_LZ || (dig_idx_nxt == 2'd0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(dig_idx_nxt) && disp_nxt[j*4 +: 4] != 4'd0) lit_nxt = 1'b1;
    end
  end

  // Conversion FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      bcd_sr   <= '0;
      bin_sr   <= '0;
      bit_cnt  <= '0;
      disp_bcd <= '0;
    end else begin
      case (state)
        IDLE: if (value_valid) begin
          state   <= CONVERT;
          busy    <= 1'b1;
          bin_sr  <= value_in;
          bcd_sr  <= '0;
          bit_cnt <= '0;
        end
        CONVERT: begin
          {bcd_sr, bin_sr} <= step_res;
          bit_cnt          <= bit_cnt + 4'd1;
          if (conv_done) begin
            state    <= IDLE;
            busy     <= 1'b0;
            disp_bcd <= disp_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Digit scan, free-running and independent of conversion
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt  <= '0;
      dig_idx  <= '0;
      digit_en <= 4'b0001;
    end else begin
      div_cnt  <= scan_wrap ? '0 : div_cnt + DIV_W'(1);
      dig_idx  <= dig_idx_nxt;
      digit_en <= lit_nxt ? (4'b0001 << dig_idx_nxt) : 4'b0000;
    end
  end

  assign cur_nib = disp_bcd[dig_idx*4 +: 4];

  seg7 u_seg7 (
    .counter  (cur_nib),
    .segments (segments)
  );

endmodule

// File: tb/tb_range_bcd_display.sv
module tb_range_bcd_display;

  localparam int SD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        value_valid = 1'b0;
  logic [11:0] value_in = 12'd0;
  logic        busy_a, busy_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  en_a, en_b;

  always #5 clock = ~clock;

  range_bcd_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clock(clock), .reset(reset), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_a), .segments(seg_a), .digit_en(en_a)
  );

  range_bcd_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_b), .segments(seg_b), .digit_en(en_b)
  );

  int   checks = 0;
  int   errors = 0;
  int   m_div = 0, m_dig = 0, m_busy = 0, exp_val = 0;
  int   sb[$];
  logic prev_busy = 1'b0;
  bit   rst_edge = 1'b0;

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int digit_of(input int v, input int i);
    int r;
    r = v;
    for (int k = 0; k < i; k++) r = r / 10;
    return r % 10;
  endfunction

  function automatic logic [3:0] en_ref(input int v, input int idx, input bit blank);
    int msd;
    logic [3:0] one;
    msd = 0;
    for (int i = 0; i < 4; i++) if (digit_of(v, i) != 0) msd = i;
    one = 4'b0001 << idx;
    return (!blank || idx <= msd) ? one : 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the reference model at the edge, then compare
  // every DUT output on the falling edge.
  task automatic step();
    @(posedge clock);
    rst_edge = reset;
    if (reset) begin
      m_div = 0; m_dig = 0; m_busy = 0; exp_val = 0;
      sb.delete();
    end else begin
      if (m_div == SD - 1) begin m_div = 0; m_dig = (m_dig + 1) % 4; end
      else m_div++;
      if (m_busy > 0) m_busy--;
      else if (value_valid) begin m_busy = 12; sb.push_back(int'(value_in)); end
    end
    @(negedge clock);
    if (prev_busy && !busy_a && !rst_edge) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb_pop observed=empty expected=pending");
      end else exp_val = sb.pop_front();
    end
    prev_busy = busy_a;
    chk("busy_a", busy_a, m_busy != 0);
    chk("busy_b", busy_b, m_busy != 0);
    chk("digit_en_blank", en_a, en_ref(exp_val, m_dig, 1'b1));
    chk("digit_en_noblank", en_b, en_ref(exp_val, m_dig, 1'b0));
    chk("segments_a", seg_a, seg_ref(digit_of(exp_val, m_dig)));
    chk("segments_b", seg_b, seg_ref(digit_of(exp_val, m_dig)));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic strobe(input int v);
    value_in = 12'(v);
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
  endtask

  task automatic wait_idle();
    while (m_busy != 0) step();
  endtask

  initial begin
    // reset state, held through a full scan
    reset = 1'b1; run(2);
    reset = 1'b0; run(4 * SD);

    // full-scale value: 4095 -> 5,9,0,4 with the hundreds zero lit
    strobe(4095); wait_idle(); run(4 * SD);

    // single digit: leading zeros blanked on dut only
    strobe(7); wait_idle(); run(4 * SD);

    // strobe while busy dropped; strobe right after busy falls taken
    strobe(1000); run(4); strobe(999); wait_idle();
    strobe(999); wait_idle(); run(4 * SD);

    // reset mid-conversion aborts with no late update
    strobe(123); run(5);
    reset = 1'b1; step();
    reset = 1'b0; run(4 * SD + 12);

    // add-3 carry cases
    strobe(59);   wait_idle(); run(4 * SD);
    strobe(1009); wait_idle(); run(4 * SD);
    strobe(2048); wait_idle(); run(4 * SD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_bcd_display.md
# range_bcd_display

Display back-end for the range-measurement chip. It accepts a 12-bit binary result with a one-cycle load strobe and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine, 12 cycles per result. It then time-multiplexes the digits onto a single 7-segment bus with one-hot digit enables. It sits directly downstream of the min/max range finder and replaces its single-nibble `seg7` hookup with a full decimal readout on `io_out[10:0]`.

## Interface
Parameters:
- `SCAN_DIV`, default 1024: clock cycles each digit stays lit. Must be ≥ 2.
- `BLANK_LZ`, default 1: when 1, leading-zero digits are blanked. Digit 0 is never blanked.

Ports:
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `value_in` input 12: binary value to display, 0..4095.
- `value_valid` input 1: load strobe. Sampled only when `busy` is 0.
- `busy` output 1: high while a conversion is in progress.
- `segments` output 7: segment pattern of the currently enabled digit. Encoding is identical to `seg7`.
- `digit_en` output 4: one-hot, active-high. Bit 0 is the ones digit.

## Operation
- Conversion FSM states:
  - IDLE: `busy`=0.
  - CONVERT: `busy`=1.
- IDLE → CONVERT on a clock edge with `value_valid`=1. On that edge:
  - `bin_sr` ← `value_in`.
  - `bcd_sr` ← 0.
  - `bit_cnt` ← 0.
- CONVERT, each edge:
  - Every `bcd_sr` nibble ≥ 5 gets +3.
  - Then `{bcd_sr, bin_sr}` shifts left by 1.
  - `bit_cnt` increments.
- CONVERT → IDLE on the edge where `bit_cnt`=11. On that same edge, `disp_bcd` ← the final shifted `bcd_sr`.
- `disp_bcd` (16 bits) changes only on that edge, so the display is never torn.
- `value_valid` while `busy`=1 is ignored and dropped. It is not queued.
- Arithmetic and widths:
  - `bcd_sr` is 16 bits, `bin_sr` is 12 bits, `bit_cnt` is 4 bits.
  - The add-3 never overflows a nibble, because inputs ≤ 4095 need only 4 digits.
- Scan:
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps.
  - On the wrap, `dig_idx` advances 0→1→2→3→0.
  - The scan runs continuously and independently of conversion.
- Outputs:
  - `digit_en` = 1 << `dig_idx`.
  - When `BLANK_LZ`=1 and digit `dig_idx` is above the most significant nonzero digit of `disp_bcd`, `digit_en` = 0 for that slot instead. The scan slot is still consumed.
  - `segments` = `seg7`(`disp_bcd` nibble `dig_idx`).

## Timing
- Reset values:
  - State IDLE, `busy`=0.
  - `disp_bcd`=0, `bcd_sr`=0, `bin_sr`=0.
  - `div_cnt`=0, `dig_idx`=0.
  - Therefore `digit_en`=0001 and `segments`=`seg7`(0).
- Latency:
  - Strobe sampled at edge E.
  - `busy` is high from after E through edge E+12, i.e. exactly 12 cycles.
  - New `disp_bcd` is visible after E+12.
- Back-to-back strobes:
  - A strobe in the first cycle after `busy` falls is accepted.
  - Minimum strobe spacing is 13 cycles. The old display holds until the new conversion completes.
- Register map:
  - `busy` and `digit_en` come from registers.
  - `segments` is combinational from registered `dig_idx`/`disp_bcd` through a single `seg7` instance. Glitches between digits are acceptable.
- `dig_idx` changes on the edge where `div_cnt`=SCAN_DIV-1. Each digit is lit for exactly `SCAN_DIV` cycles.
- Reset mid-conversion:
  - Aborts immediately and returns to the reset values.
  - No late `disp_bcd` update occurs.
- Reset dominates `value_valid` on the same edge.

## Structure
- Package `range_display_pkg` holds:
  - The FSM enum `{IDLE, CONVERT}`.
  - `NUM_DIGITS`=4, `BIN_W`=12, `BCD_W`=16.
  - `CONV_CYCLES`=12.
  - The add-3 threshold (5).
- Sub-modules:
  - Reuse the existing `seg7` (`counter[3:0]` → `segments[6:0]`) as the single decoder instance.
  - The double-dabble iteration step may be a function in the package. No new sub-module is required.

## Test plan
- Reset → `busy`=0, `digit_en`=0001, `segments`=`seg7`(0). This holds across 4×`SCAN_DIV` cycles with `BLANK_LZ`=1.
- `value_in`=4095 strobed, `SCAN_DIV`=4:
  - `busy` is high for exactly 12 cycles.
  - Digits then read 5,9,0,4 on `digit_en` 0001,0010,0100,1000, each for 4 cycles.
  - The 0 in the hundreds place is not blanked.
- `value_in`=7 with `BLANK_LZ`=1:
  - Only `digit_en`=0001 is ever asserted, showing `seg7`(7).
  - The other three slots read `digit_en`=0000 for 4 cycles each.
  - With `BLANK_LZ`=0, all four slots are enabled, showing 0,0,0,7.
- `value_in`=1000 strobed, then 999 strobed at busy cycle 5:
  - 999 is ignored and the display becomes 1000.
  - 999 strobed the cycle after `busy` falls is accepted; the display shows 1000 until 12 cycles later, then 999.
- `value_in`=123 strobed, reset asserted at busy cycle 6:
  - `busy`=0 next cycle and `disp_bcd`=0.
  - No update ever appears.
- Add-3 carry check: 59, 1009, 2048 each display exactly 0059, 1009, 2048, with nibble order checked against `digit_en`.
